// File: rtl/ecc_ladder_pkg.sv
// Shared types for the Montgomery-ladder sequencer: point-unit opcodes,
// register selectors, job status codes and controller states.
package ecc_ladder_pkg;

    typedef enum logic [1:0] {
        OP_INF  = 2'd0,
        OP_COPY = 2'd1,
        OP_ADD  = 2'd2,
        OP_DBL  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        REG_R0 = 2'd0,
        REG_R1 = 2'd1,
        REG_G  = 2'd2
    } reg_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_ZERO_SCALAR = 2'd1,
        ERR_UNIT_FAULT  = 2'd2,
        ERR_ABORTED     = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT0 = 3'd1,
        ST_INIT1 = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

    localparam logic PH_ADD = 1'b0;
    localparam logic PH_DBL = 1'b1;

endpackage

// File: rtl/ecc_ladder_if.sv
// Command/response link between the ladder sequencer (master) and the
// shared EC point-arithmetic unit (slave).
interface ecc_ladder_if;
    import ecc_ladder_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    op_e  cmd_op;
    reg_e cmd_src_a;
    reg_e cmd_src_b;
    reg_e cmd_dst;
    logic rsp_valid;
    logic rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        input  cmd_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        output cmd_ready, rsp_valid, rsp_err
    );

endinterface

// File: rtl/ecc_ladder_step_dec.sv
// One ladder step decoded from the current scalar bit and ADD/DBL phase.
// Only operand routing depends on the key bit, never the opcode sequence.
module ecc_ladder_step_dec
    import ecc_ladder_pkg::*;
(
    input  logic kbit,
    input  logic phase,
    output op_e  op,
    output reg_e src_a,
    output reg_e src_b,
    output reg_e dst
);

    always_comb begin
        if (phase == PH_ADD) begin
            op    = OP_ADD;
            src_a = REG_R0;
            src_b = REG_R1;
            dst   = kbit ? REG_R0 : REG_R1;
        end else begin
            op    = OP_DBL;
            src_a = kbit ? REG_R1 : REG_R0;
            src_b = REG_R0;
            dst   = kbit ? REG_R1 : REG_R0;
        end
    end

endmodule

// File: rtl/ecc_ladder_ctrl.sv
// Constant-time Montgomery-ladder sequencer for Q = k*G: issues INF, COPY,
// then an ADD/DBL pair per scalar bit to the point unit, one command in flight.
module ecc_ladder_ctrl
    import ecc_ladder_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                start_rdy,
    input  logic [KEY_BITS-1:0] scalar,
    input  logic                abort,
    ecc_ladder_if.master        pu,
    output logic                busy,
    output logic                done,
    output err_e                err
);

    localparam int IDX_W = $clog2(KEY_BITS);

    state_e             state_q, state_d, src_q;
    err_e               err_q, err_d;
    logic [KEY_BITS-1:0] k_q;
    logic [IDX_W-1:0]   idx_q;
    logic               phase_q;
    logic               abort_q;
    logic               accept, issuing, last_step;
    op_e                dec_op;
    reg_e               dec_src_a, dec_src_b, dec_dst;

    assign start_rdy = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;
    assign accept    = start && start_rdy;
    assign issuing   = (state_q == ST_INIT0) || (state_q == ST_INIT1) || (state_q == ST_ISSUE);
    assign last_step = (phase_q == PH_DBL) && (idx_q == '0);

    ecc_ladder_step_dec u_dec (
        .kbit  (k_q[idx_q]),
        .phase (phase_q),
        .op    (dec_op),
        .src_a (dec_src_a),
        .src_b (dec_src_b),
        .dst   (dec_dst)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (scalar == '0) begin
                        state_d = ST_FIN;
                        err_d   = ERR_ZERO_SCALAR;
                    end else begin
                        state_d = ST_INIT0;
                        err_d   = ERR_NONE;
                    end
                end
            end
            ST_INIT0, ST_INIT1, ST_ISSUE: begin
                // An accepted command must complete, so abort only wins before the handshake.
                if (pu.cmd_ready) begin
                    state_d = ST_WAIT;
                end else if (abort) begin
                    state_d = ST_FIN;
                    err_d   = ERR_ABORTED;
                end
            end
            ST_WAIT: begin
                if (pu.rsp_valid) begin
                    if (pu.rsp_err) begin
                        state_d = ST_FIN;
                        err_d   = ERR_UNIT_FAULT;
                    end else if (abort_q || abort) begin
                        state_d = ST_FIN;
                        err_d   = ERR_ABORTED;
                    end else if (src_q == ST_INIT0) begin
                        state_d = ST_INIT1;
                    end else if (src_q == ST_INIT1) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = last_step ? ST_FIN : ST_ISSUE;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pu.cmd_valid = issuing;
        pu.cmd_op    = OP_INF;
        pu.cmd_src_a = REG_R0;
        pu.cmd_src_b = REG_R0;
        pu.cmd_dst   = REG_R0;
        case (state_q)
            ST_INIT1: begin
                pu.cmd_op    = OP_COPY;
                pu.cmd_src_a = REG_G;
                pu.cmd_dst   = REG_R1;
            end
            ST_ISSUE: begin
                pu.cmd_op    = dec_op;
                pu.cmd_src_a = dec_src_a;
                pu.cmd_src_b = dec_src_b;
                pu.cmd_dst   = dec_dst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= ST_IDLE;
            err_q   <= ERR_NONE;
            idx_q   <= '0;
            phase_q <= PH_ADD;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                idx_q   <= IDX_W'(KEY_BITS - 1);
                phase_q <= PH_ADD;
                abort_q <= 1'b0;
            end else begin
                if (busy && abort) abort_q <= 1'b1;
                if (issuing && pu.cmd_ready) src_q <= state_q;
                if ((state_q == ST_WAIT) && pu.rsp_valid && (src_q == ST_ISSUE)) begin
                    if (phase_q == PH_DBL) idx_q <= idx_q - 1'b1;
                    phase_q <= ~phase_q;
                end
            end
        end
    end

    // Key material is wiped as soon as the job finishes, whatever the outcome.
    always_ff @(posedge clk) begin
        if (accept) k_q <= scalar;
        else if (state_q == ST_FIN) k_q <= '0;
    end

endmodule

// File: tb/tb_ecc_ladder_ctrl.sv
// Randomised scoreboard bench for ecc_ladder_ctrl: a 4-bit build exercised with
// stalls, faults, aborts and reset, plus one job on the default 256-bit build.
module tb_ecc_ladder_ctrl;
    import ecc_ladder_pkg::*;

    typedef struct {
        logic [1:0] err;
        int         lat;
    } dexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n;
    logic         start_a, start_rdy_a, abort_a, busy_a, done_a;
    logic [3:0]   scalar_a;
    err_e         err_a;
    logic         start_b, start_rdy_b, abort_b, busy_b, done_b;
    logic [255:0] scalar_b;
    err_e         err_b;

    ecc_ladder_if ifa ();
    ecc_ladder_if ifb ();

    ecc_ladder_ctrl #(.KEY_BITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .start_rdy(start_rdy_a),
        .scalar(scalar_a), .abort(abort_a), .pu(ifa), .busy(busy_a),
        .done(done_a), .err(err_a)
    );

    ecc_ladder_ctrl dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .start_rdy(start_rdy_b),
        .scalar(scalar_b), .abort(abort_b), .pu(ifb), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    logic [7:0] fields_a, fields_b;
    assign fields_a = {ifa.cmd_op, ifa.cmd_src_a, ifa.cmd_src_b, ifa.cmd_dst};
    assign fields_b = {ifb.cmd_op, ifb.cmd_src_a, ifb.cmd_src_b, ifb.cmd_dst};

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    dexp_t      qda[$];
    dexp_t      qdb[$];

    int n_chk = 0, n_pass = 0, timeouts = 0;
    int hs_total_a = 0, hs_total_b = 0, stall_cnt_a = 0;
    int err_at_a = -1, stall_at_a = -1, stall_len_a = 0;
    logic ign_a = 1'b0, all_done = 1'b0;

    // Reference ladder: command n of a job on scalar k, encoded {op,src_a,src_b,dst}.
    function automatic logic [7:0] exp_cmd(input logic [255:0] k, input int nbits, input int n);
        int j, i;
        logic b;
        if (n == 0) return {2'd0, 2'd0, 2'd0, 2'd0};
        if (n == 1) return {2'd1, 2'd2, 2'd0, 2'd1};
        j = n - 2;
        i = nbits - 1 - j / 2;
        b = k[i];
        if (j % 2 == 0) return {2'd2, 2'd0, 2'd1, b ? 2'd0 : 2'd1};
        return {2'd3, b ? 2'd1 : 2'd0, 2'd0, b ? 2'd1 : 2'd0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    // Point-unit model: 1-cycle response after each handshake, optional stall and fault.
    initial begin
        logic hs_a, hs_b;
        ifa.cmd_ready = 1'b1; ifa.rsp_valid = 1'b0; ifa.rsp_err = 1'b0;
        ifb.cmd_ready = 1'b1; ifb.rsp_valid = 1'b0; ifb.rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            hs_a = ifa.cmd_valid && ifa.cmd_ready && rst_n;
            hs_b = ifb.cmd_valid && ifb.cmd_ready && rst_n;
            if (hs_total_a == stall_at_a && ifa.cmd_valid && !ifa.cmd_ready) stall_cnt_a++;
            @(posedge clk);
            #1;
            ifa.rsp_valid = hs_a;
            ifa.rsp_err   = hs_a && (hs_total_a == err_at_a);
            if (hs_a) hs_total_a++;
            if (hs_total_a != stall_at_a) stall_cnt_a = 0;
            ifa.cmd_ready = !((hs_total_a == stall_at_a) && (stall_cnt_a < stall_len_a));
            ifb.rsp_valid = hs_b;
            if (hs_b) hs_total_b++;
        end
    end

    // Monitor: pops expectations whenever the DUTs present a command or a done pulse.
    initial begin
        logic       hold_a = 1'b0, abort_prev_a = 1'b0;
        logic [7:0] prev_a = '0;
        int         acc_a = 0, acc_b = 0;
        dexp_t      d;
        while (!all_done) begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_start_rdy_a", 32'(start_rdy_a), 32'd1);
                chk("rst_cmd_valid_a", 32'(ifa.cmd_valid), 32'd0);
                chk("rst_busy_a", 32'(busy_a), 32'd0);
                chk("rst_done_a", 32'(done_a), 32'd0);
                chk("rst_err_a", 32'(err_a), 32'd0);
                chk("rst_start_rdy_b", 32'(start_rdy_b), 32'd1);
                chk("rst_cmd_valid_b", 32'(ifb.cmd_valid), 32'd0);
                chk("rst_done_b", 32'(done_b), 32'd0);
                hold_a = 1'b0;
            end else begin
                if (!ign_a) begin
                    if (hold_a && !abort_prev_a)
                        chk("hold_stable_a", 32'({ifa.cmd_valid, fields_a}), 32'({1'b1, prev_a}));
                    if (start_a && start_rdy_a) acc_a = cyc;
                    if (ifa.cmd_valid && ifa.cmd_ready) begin
                        chk("busy_during_cmd_a", 32'(busy_a), 32'd1);
                        if (qa.size() == 0) begin
                            n_chk++;
                            $display("FAIL cmd_extra_a: got cmd 0x%0h, expected no command", fields_a);
                        end else chk("cmd_a", 32'(fields_a), 32'(qa.pop_front()));
                    end
                    if (done_a) begin
                        chk("busy_at_done_a", 32'(busy_a), 32'd0);
                        if (qda.size() == 0) begin
                            n_chk++;
                            $display("FAIL done_extra_a: got done err=%0d, expected no done", err_a);
                        end else begin
                            d = qda.pop_front();
                            chk("err_a", 32'(err_a), 32'(d.err));
                            chk("latency_a", 32'(cyc - acc_a), 32'(d.lat));
                        end
                    end
                end
                hold_a       = ifa.cmd_valid && !ifa.cmd_ready && !ign_a;
                prev_a       = fields_a;
                abort_prev_a = abort_a;
                if (start_b && start_rdy_b) acc_b = cyc;
                if (ifb.cmd_valid && ifb.cmd_ready) begin
                    if (qb.size() == 0) begin
                        n_chk++;
                        $display("FAIL cmd_extra_b: got cmd 0x%0h, expected no command", fields_b);
                    end else chk("cmd_b", 32'(fields_b), 32'(qb.pop_front()));
                end
                if (done_b) begin
                    if (qdb.size() == 0) begin
                        n_chk++;
                        $display("FAIL done_extra_b: got done err=%0d, expected no done", err_b);
                    end else begin
                        d = qdb.pop_front();
                        chk("err_b", 32'(err_b), 32'(d.err));
                        chk("latency_b", 32'(cyc - acc_b), 32'(d.lat));
                    end
                end
            end
        end
        chk("leftover_cmds_a", 32'(qa.size()), 32'd0);
        chk("leftover_done_a", 32'(qda.size()), 32'd0);
        chk("leftover_cmds_b", 32'(qb.size()), 32'd0);
        chk("leftover_done_b", 32'(qdb.size()), 32'd0);
        chk("timeouts", 32'(timeouts), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    task automatic wait_done_a();
        logic seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done_a) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeouts++;
        @(posedge clk);
        #1;
    endtask

    // One 4-bit job; relative indices are command numbers within the job, -1 = unused.
    task automatic run_a(input logic [3:0] k, input int stall_rel, input int stall_len,
                         input int err_rel, input int abort_rel, input logic poke);
        int          ntot, n, lat, base;
        logic [1:0]  e;
        logic [255:0] kx;
        dexp_t       d;
        kx   = {252'b0, k};
        ntot = (k == 4'd0) ? 0 : 10;
        n    = ntot;
        e    = (k == 4'd0) ? 2'd1 : 2'd0;
        if (ntot > 0 && err_rel >= 0 && err_rel < ntot) begin
            n = err_rel + 1;
            e = 2'd2;
        end else if (ntot > 0 && abort_rel >= 0 && abort_rel < ntot) begin
            n = abort_rel + 1;
            e = 2'd3;
        end
        lat = 2 * n + 1 + ((stall_rel >= 0 && stall_rel < n) ? stall_len : 0);
        for (int i = 0; i < n; i++) qa.push_back(exp_cmd(kx, 4, i));
        d.err = e;
        d.lat = lat;
        qda.push_back(d);
        base        = hs_total_a;
        err_at_a    = (err_rel < 0) ? -1 : base + err_rel;
        stall_at_a  = (stall_rel < 0) ? -1 : base + stall_rel;
        stall_len_a = stall_len;
        if (abort_rel >= 0) begin
            abort_a = 1'b1;
            @(posedge clk);
            #1 abort_a = 1'b0;
        end
        start_a  = 1'b1;
        scalar_a = k;
        @(posedge clk);
        #1 start_a = 1'b0;
        if (poke) begin
            @(posedge clk);
            #1 start_a = 1'b1;
            scalar_a = ~k;
            @(posedge clk);
            #1 start_a = 1'b0;
            scalar_a = k;
        end
        if (abort_rel >= 0) begin
            logic hit = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk);
                #2;
                if (hs_total_a == base + abort_rel + 1) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit) timeouts++;
            abort_a = 1'b1;
            @(posedge clk);
            #1 abort_a = 1'b0;
        end
        wait_done_a();
    endtask

    initial begin
        dexp_t d;
        logic  seen;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; scalar_a = '0;
        start_b = 1'b0; abort_b = 1'b0; scalar_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_a(4'b1011, -1, 0, -1, -1, 1'b1);
        run_a(4'b0000, -1, 0, -1, -1, 1'b0);
        run_a(4'b1011,  2, 5, -1, -1, 1'b0);
        run_a(4'b1101, -1, 0,  5, -1, 1'b0);
        run_a(4'b1111, -1, 0, -1,  3, 1'b0);

        ign_a = 1'b1;
        start_a = 1'b1;
        scalar_a = 4'b1010;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ign_a = 1'b0;
        run_a(4'b0001, -1, 0, -1, -1, 1'b0);

        for (int j = 0; j < 8; j++) begin
            run_a(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1,
                  int'($urandom_range(1, 4)), -1, -1, 1'b0);
        end

        for (int w = 0; w < 8; w++) scalar_b[32*w +: 32] = $urandom;
        scalar_b[255] = 1'b1;
        for (int i = 0; i < 514; i++) qb.push_back(exp_cmd(scalar_b, 256, i));
        d.err = 2'd0;
        d.lat = 2 * 514 + 1;
        qdb.push_back(d);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (done_b) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeouts++;
        repeat (2) @(posedge clk);
        #1 all_done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
